// File: rtl/query_row_reader.sv
// Streams a burst of words out of a synchronous-read RAM into a 2-entry output FIFO.
// Reads are throttled so buffered plus in-flight words never exceed the FIFO depth.
module query_row_reader #(
  parameter int DATA_WIDTH = 55,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_adr,
  input  logic [ADDR_WIDTH:0]   num_patches,
  output logic                  ren,
  output logic [ADDR_WIDTH-1:0] radr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            fifo_cnt;
  logic                  push, pop;
  logic [2:0]            occ;

  assign push      = inflight;
  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  // Slots that will be taken once this edge retires; a new read may only claim a free one.
  assign occ       = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ren       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (num_patches == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        if (occ < 3'd2) begin
          ren = 1'b1;
          if (remaining == (ADDR_WIDTH+1)'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Finish on the edge that pops the last word, so done follows it by one cycle.
        if (!inflight && (fifo_cnt - {1'b0, pop}) == 2'd0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == ISSUE) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      radr        <= '0;
      remaining   <= '0;
      inflight    <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (state == IDLE && start && num_patches != '0) begin
        radr      <= start_adr;
        remaining <= (num_patches > DEPTH_C) ? DEPTH_C : num_patches;
      end else if (ren) begin
        radr      <= radr + ADDR_WIDTH'(1);
        remaining <= remaining - (ADDR_WIDTH+1)'(1);
      end
      inflight <= ren;
      if (push) begin
        fifo_mem[wr_ptr] <= rdata;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_query_row_reader.sv
// Randomized bench for query_row_reader: a RAM model plus an expected-word queue per burst.
module tb_query_row_reader;
  localparam int DW = 55;
  localparam int AW = 7;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_adr = '0;
  logic [AW:0]   num_patches = '0;
  logic          ren;
  logic [AW-1:0] radr;
  logic [DW-1:0] rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          busy, done;

  query_row_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_adr(start_adr),
    .num_patches(num_patches), .ren(ren), .radr(radr), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) if (ren) rdata <= ram[radr];

  int n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Reference bookkeeping for the current burst
  int            cyc = 0;
  logic [DW-1:0] exp_q[$];
  int            b_adr, ren_idx, xfers, outstanding, done_cnt, done_cyc, last_xfer;
  bit            busy_seen, prev_hold, tput_on;
  logic [DW-1:0] prev_data;

  always @(posedge clk) cyc++;

  always @(negedge clk) if (rst_n) begin
    if (ren) begin
      chk("radr", 64'(radr), 64'((b_adr + ren_idx) % DEPTH));
      ren_idx++;
      outstanding++;
    end
    if (prev_hold) begin
      chk("hold_vld", 64'(out_valid), 64'd1);
      chk("hold_data", 64'(out_data), 64'(prev_data));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("extra_word", 64'(out_data), 64'hdead);
      else chk("data", 64'(out_data), 64'(exp_q.pop_front()));
      if (tput_on && xfers > 0) chk("tput", 64'(cyc - last_xfer), 64'd1);
      xfers++;
      outstanding--;
      last_xfer = cyc;
    end
    if (outstanding > 2) chk("readahead", 64'(outstanding), 64'd2);
    prev_hold = out_valid && !out_ready;
    prev_data = out_data;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_seen = 1'b1;
  end

  task automatic prep(input int adr, input int n);
    int eff;
    eff = (n > DEPTH) ? DEPTH : n;
    exp_q.delete();
    for (int k = 0; k < eff; k++) exp_q.push_back(ram[(adr + k) % DEPTH]);
    b_adr = adr; ren_idx = 0; xfers = 0; outstanding = 0; done_cnt = 0;
    busy_seen = 1'b0; prev_hold = 1'b0;
  endtask

  // stall: cycles of out_ready=0 after start; rnd: random ready afterwards; mid: re-issue start
  task automatic run_burst(input int adr, input int n, input int stall, input bit rnd, input bit mid);
    int eff, s_cyc, c;
    eff = (n > DEPTH) ? DEPTH : n;
    prep(adr, n);
    tput_on = (stall == 0) && !rnd;
    @(posedge clk); #1;
    start = 1'b1; start_adr = AW'(adr); num_patches = (AW+1)'(n);
    out_ready = (stall == 0);
    s_cyc = cyc;
    for (c = 0; c < 3000 && done_cnt == 0; c++) begin
      @(posedge clk); #1;
      start = (mid && c == 2);
      if (mid && c == 2) begin start_adr = start_adr + AW'(37); num_patches = 8'd3; end
      if (c < stall) out_ready = 1'b0;
      else out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall >= 4 && c == stall) chk("stall_reads", 64'(ren_idx), 64'd2);
      @(negedge clk);
    end
    if (done_cnt == 0) chk("timeout", 64'd0, 64'd1);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("done_cnt", 64'(done_cnt), 64'd1);
    chk("left", 64'(exp_q.size()), 64'd0);
    chk("reads", 64'(ren_idx), 64'(eff));
    chk("xfers", 64'(xfers), 64'(eff));
    chk("busy_seen", 64'(busy_seen), 64'(eff > 0));
    if (eff > 0) chk("done_lat", 64'(done_cyc - last_xfer), 64'd1);
    else         chk("done_lat0", 64'(done_cyc - s_cyc), 64'd1);
  endtask

  initial begin
    logic [63:0] r;
    for (int i = 0; i < DEPTH; i++) begin
      r = {$urandom, $urandom};
      ram[i] = r[DW-1:0];
    end
    #1;
    chk("rst_ren", 64'(ren), 64'd0);
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_burst(0, 5, 0, 0, 0);
    run_burst(126, 4, 0, 0, 0);
    run_burst(DEPTH - 1, 2, 0, 0, 0);
    run_burst(10, 6, 10, 0, 0);
    run_burst(50, 0, 0, 0, 0);
    run_burst(20, 8, 0, 0, 1);
    run_burst(5, 200, 0, 0, 0);
    run_burst(90, 1, 0, 0, 0);
    for (int t = 0; t < 10; t++)
      run_burst($urandom_range(0, DEPTH - 1), $urandom_range(1, 40), $urandom_range(0, 6), 1, 0);

    // Reset in the middle of a burst, then a fresh burst must run cleanly
    prep(30, 10);
    tput_on = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; start_adr = AW'(30); num_patches = 8'd10; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 100 && xfers < 3; c++) @(negedge clk);
    chk("pre_rst_xfers", 64'(xfers), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ren", 64'(ren), 64'd0);
    chk("mrst_radr", 64'(radr), 64'd0);
    chk("mrst_vld", 64'(out_valid), 64'd0);
    chk("mrst_data", 64'(out_data), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #1 chk("mrst_done2", 64'(done), 64'd0);
    rst_n = 1'b1;
    run_burst(100, 7, 3, 0, 0);
    run_burst(64, 12, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
